// File: rtl/rv32im_writeback_arbiter.sv
// -----------------------------------------------------------------------------
// rv32im_writeback_arbiter
//
// Purpose:
//   Drives the single write port of the RV32IM register file. Results from
//   the LSU, the MUL/DIV unit (MDU) and the ALU are arbitrated with fixed
//   priority LSU > MDU > ALU, and at most one result is written per cycle.
//   Load data from the LSU is byte/half-selected and sign/zero-extended
//   before it is written. A busy scoreboard with one bit per architectural
//   register lets decode detect RAW and WAW hazards.
//
// Ports:
//   clk_i, rst_n_i          clock (posedge), asynchronous active-low reset
//   alu_* / mdu_* / lsu_*   result sources (valid/ready/rd/data)
//   lsu_funct3_i            load type (LB/LH/LW/LBU/LHU)
//   lsu_addr_lo_i           byte offset of the load address
//   issue_valid_i/rd_i      decode issues an instruction that writes rd
//   rs1_addr_i, rs2_addr_i  hazard query addresses
//   rs1/rs2/rd_busy_o       scoreboard lookups (combinational)
//   rf_we_o, rf_rd_addr_o,
//   rf_val_rd_o             registered register-file write port
//
// Handshake: a source raises valid with rd/data and holds all of them
// stable until it sees valid & ready in the same cycle; that cycle is the
// transfer. Readys depend only on the valids of higher-priority sources,
// never on the source's own valid, so there is no combinational loop
// through a source that waits for ready before asserting valid.
// -----------------------------------------------------------------------------
module rv32im_writeback_arbiter #(
   parameter int unsigned XLEN = 32,
   parameter int unsigned AW   = 5,
   parameter int unsigned NREG = 32
) (
   input  logic            clk_i,
   input  logic            rst_n_i,

   input  logic            alu_valid_i,
   output logic            alu_ready_o,
   input  logic [AW-1:0]   alu_rd_i,
   input  logic [XLEN-1:0] alu_data_i,

   input  logic            mdu_valid_i,
   output logic            mdu_ready_o,
   input  logic [AW-1:0]   mdu_rd_i,
   input  logic [XLEN-1:0] mdu_data_i,

   input  logic            lsu_valid_i,
   output logic            lsu_ready_o,
   input  logic [AW-1:0]   lsu_rd_i,
   input  logic [XLEN-1:0] lsu_data_i,
   input  logic [2:0]      lsu_funct3_i,
   input  logic [1:0]      lsu_addr_lo_i,

   input  logic            issue_valid_i,
   input  logic [AW-1:0]   issue_rd_i,
   input  logic [AW-1:0]   rs1_addr_i,
   input  logic [AW-1:0]   rs2_addr_i,
   output logic            rs1_busy_o,
   output logic            rs2_busy_o,
   output logic            rd_busy_o,

   output logic            rf_we_o,
   output logic [AW-1:0]   rf_rd_addr_o,
   output logic [XLEN-1:0] rf_val_rd_o
);

   // ---------------------------------------------------------------------
   // Load data formatting
   // ---------------------------------------------------------------------
   logic [7:0]      ld_byte;
   logic [15:0]     ld_half;
   logic [XLEN-1:0] ld_val;

   always_comb begin
      ld_byte = lsu_data_i[7:0];
      case (lsu_addr_lo_i)
         2'd0:    ld_byte = lsu_data_i[7:0];
         2'd1:    ld_byte = lsu_data_i[15:8];
         2'd2:    ld_byte = lsu_data_i[23:16];
         default: ld_byte = lsu_data_i[31:24];
      endcase

      // Halfword accesses ignore the low offset bit.
      ld_half = lsu_addr_lo_i[1] ? lsu_data_i[31:16] : lsu_data_i[15:0];

      // Unused funct3 encodings fall through to a full-word write.
      case (lsu_funct3_i)
         3'b000:  ld_val = {{(XLEN-8){ld_byte[7]}}, ld_byte};
         3'b100:  ld_val = {{(XLEN-8){1'b0}}, ld_byte};
         3'b001:  ld_val = {{(XLEN-16){ld_half[15]}}, ld_half};
         3'b101:  ld_val = {{(XLEN-16){1'b0}}, ld_half};
         default: ld_val = lsu_data_i;
      endcase
   end

   // ---------------------------------------------------------------------
   // Fixed-priority arbitration
   // ---------------------------------------------------------------------
   logic            sel_valid;
   logic [AW-1:0]   sel_rd;
   logic [XLEN-1:0] sel_data;

   assign lsu_ready_o = 1'b1;
   assign mdu_ready_o = ~lsu_valid_i;
   assign alu_ready_o = ~lsu_valid_i & ~mdu_valid_i;

   always_comb begin
      sel_valid = 1'b0;
      sel_rd    = '0;
      sel_data  = '0;
      if (lsu_valid_i) begin
         sel_valid = 1'b1;
         sel_rd    = lsu_rd_i;
         sel_data  = ld_val;
      end else if (mdu_valid_i) begin
         sel_valid = 1'b1;
         sel_rd    = mdu_rd_i;
         sel_data  = mdu_data_i;
      end else if (alu_valid_i) begin
         sel_valid = 1'b1;
         sel_rd    = alu_rd_i;
         sel_data  = alu_data_i;
      end
   end

   // ---------------------------------------------------------------------
   // Registered write port
   // ---------------------------------------------------------------------
   logic            rf_we_q,      rf_we_d;
   logic [AW-1:0]   rf_rd_addr_q, rf_rd_addr_d;
   logic [XLEN-1:0] rf_val_rd_q,  rf_val_rd_d;

   // A transfer to x0 completes the handshake but never writes; the address
   // and data registers only move on a real write and otherwise hold.
   always_comb begin
      rf_we_d      = sel_valid & (sel_rd != '0);
      rf_rd_addr_d = rf_rd_addr_q;
      rf_val_rd_d  = rf_val_rd_q;
      if (rf_we_d) begin
         rf_rd_addr_d = sel_rd;
         rf_val_rd_d  = sel_data;
      end
   end

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         rf_we_q      <= 1'b0;
         rf_rd_addr_q <= '0;
         rf_val_rd_q  <= '0;
      end else begin
         rf_we_q      <= rf_we_d;
         rf_rd_addr_q <= rf_rd_addr_d;
         rf_val_rd_q  <= rf_val_rd_d;
      end
   end

   assign rf_we_o      = rf_we_q;
   assign rf_rd_addr_o = rf_rd_addr_q;
   assign rf_val_rd_o  = rf_val_rd_q;

   // ---------------------------------------------------------------------
   // Busy scoreboard
   // ---------------------------------------------------------------------
   logic [NREG-1:0] busy_q, busy_d;

   // Clear is applied before set so that a register re-issued in the same
   // cycle its previous value is written back stays busy.
   always_comb begin
      busy_d = busy_q;
      if (rf_we_q) begin
         busy_d[rf_rd_addr_q] = 1'b0;
      end
      if (issue_valid_i && (issue_rd_i != '0)) begin
         busy_d[issue_rd_i] = 1'b1;
      end
      busy_d[0] = 1'b0;
   end

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         busy_q <= '0;
      end else begin
         busy_q <= busy_d;
      end
   end

   // No bypass: a register reads busy until the edge after its write.
   assign rs1_busy_o = (rs1_addr_i != '0) & busy_q[rs1_addr_i];
   assign rs2_busy_o = (rs2_addr_i != '0) & busy_q[rs2_addr_i];
   assign rd_busy_o  = (issue_rd_i != '0) & busy_q[issue_rd_i];

endmodule
